// File: rtl/decimal_entry_accumulator.sv
// Keypad-to-binary decimal entry: accumulates one-hot digit presses, commits on enter, aborts on clear.
// Optional backspace support (bksp port plus divide-by-ten path) when DIGIT_BACKSPACE_EN is defined.
module decimal_entry_accumulator #(
    parameter  int unsigned MAX_DIGITS = 4,
    parameter  int unsigned OUT_W      = 14,
    parameter  int unsigned WRAP_MODE  = 0,
    localparam int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       inputNums,
    input  logic             enter,
    input  logic             clear,
`ifdef DIGIT_BACKSPACE_EN
    input  logic             bksp,
`endif
    output logic [OUT_W-1:0] entry_val,
    output logic [CNT_W-1:0] digit_count,
    output logic [OUT_W-1:0] out_val,
    output logic             out_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned     MUL_W = OUT_W + 4;
    localparam longint unsigned POW10 = 64'(10) ** MAX_DIGITS;

    // Elaboration-time parameter sanity checks.
    if (MAX_DIGITS < 1 || MAX_DIGITS > 9) begin : g_bad_digits
        $error("MAX_DIGITS must be in 1..9");
    end
    if (OUT_W < $clog2(POW10)) begin : g_bad_width
        $error("OUT_W too narrow for MAX_DIGITS decimal digits");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ENTRY = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [9:0]       r_nums_q;
    logic [9:0]       r_nums_qq;
    logic             r_enter_q;
    logic             r_enter_qq;
    logic             r_clear_q;
    logic             r_clear_qq;
    logic [OUT_W-1:0] r_entry_val;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_out_val;
    logic             r_out_valid;
    logic             r_overflow;
    logic             r_busy;

    logic [OUT_W-1:0] w_val_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_ovf_nxt;
    logic             w_digit_evt;
    logic             w_enter_evt;
    logic             w_clear_evt;
    logic [3:0]       w_digit;
    logic [OUT_W-1:0] w_acc;
    logic [CNT_W-1:0] w_cnt_inc;

    // A digit press needs a clean one-hot code following an all-zero (released) sample.
    assign w_digit_evt = $onehot(r_nums_q) && (r_nums_qq == 10'd0);
    assign w_enter_evt = r_enter_q & ~r_enter_qq;
    assign w_clear_evt = r_clear_q & ~r_clear_qq;
    assign w_acc       = OUT_W'(MUL_W'(r_entry_val) * MUL_W'(10) + MUL_W'(w_digit));
    assign w_cnt_inc   = r_count + CNT_W'(1);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_nums_q[i]) begin
                w_digit = 4'(i);
            end
        end
    end

`ifdef DIGIT_BACKSPACE_EN
    logic r_bksp_q;
    logic r_bksp_qq;
    logic w_bksp_evt;

    assign w_bksp_evt = r_bksp_q & ~r_bksp_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bksp_q  <= 1'b0;
            r_bksp_qq <= 1'b0;
        end else begin
            r_bksp_q  <= bksp;
            r_bksp_qq <= r_bksp_q;
        end
    end
`endif

    // Next-state and next-output logic; priority clear > enter > bksp > digit.
    always_comb begin
        w_state_nxt     = r_state;
        w_val_nxt       = r_entry_val;
        w_cnt_nxt       = r_count;
        w_out_nxt       = r_out_val;
        w_out_valid_nxt = 1'b0;
        w_ovf_nxt       = 1'b0;
        if (w_clear_evt) begin
            w_state_nxt = S_EMPTY;
            w_val_nxt   = '0;
            w_cnt_nxt   = '0;
            w_out_nxt   = '0;
        end else if (w_enter_evt) begin
            w_state_nxt     = S_EMPTY;
            w_out_nxt       = r_entry_val;
            w_out_valid_nxt = 1'b1;
            w_val_nxt       = '0;
            w_cnt_nxt       = '0;
        end
`ifdef DIGIT_BACKSPACE_EN
        else if (w_bksp_evt) begin
            if (r_state != S_EMPTY) begin
                w_val_nxt   = r_entry_val / OUT_W'(10);
                w_cnt_nxt   = r_count - CNT_W'(1);
                w_state_nxt = (r_count == CNT_W'(1)) ? S_EMPTY : S_ENTRY;
            end
        end
`endif
        else if (w_digit_evt) begin
            if (r_state == S_FULL) begin
                w_ovf_nxt = 1'b1;
                if (WRAP_MODE != 0) begin
                    w_val_nxt   = OUT_W'(w_digit);
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (MAX_DIGITS == 1) ? S_FULL : S_ENTRY;
                end
            end else begin
                w_val_nxt   = w_acc;
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = (w_cnt_inc == CNT_W'(MAX_DIGITS)) ? S_FULL : S_ENTRY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_nums_q    <= '0;
            r_nums_qq   <= '0;
            r_enter_q   <= 1'b0;
            r_enter_qq  <= 1'b0;
            r_clear_q   <= 1'b0;
            r_clear_qq  <= 1'b0;
            r_entry_val <= '0;
            r_count     <= '0;
            r_out_val   <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nums_q    <= inputNums;
            r_nums_qq   <= r_nums_q;
            r_enter_q   <= enter;
            r_enter_qq  <= r_enter_q;
            r_clear_q   <= clear;
            r_clear_qq  <= r_clear_q;
            r_entry_val <= w_val_nxt;
            r_count     <= w_cnt_nxt;
            r_out_val   <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overflow  <= w_ovf_nxt;
            r_busy      <= (w_state_nxt != S_EMPTY);
        end
    end

    assign entry_val   = r_entry_val;
    assign digit_count = r_count;
    assign out_val     = r_out_val;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule

// File: doc/decimal_entry_accumulator.md
Name: decimal_entry_accumulator

Overview:
Parametrised keypad-to-binary entry block, successor to the single-width keypad input stage.
- Accepts one-hot decimal key lines plus enter and clear strobes.
- Builds a binary value one digit at a time and commits it to a registered output on enter.
- Adds a configurable digit count, a selectable overflow policy, a digit counter and valid/overflow strobes.
- Sits between the keypad/debounce front end and the arithmetic/display datapath.

Parameters:
MAX_DIGITS, 4, maximum decimal digits per entry (1..9).
OUT_W, 14, width of entry_val/out_val; must be >= ceil(log2(10^MAX_DIGITS)), checked at elaboration.
WRAP_MODE, 0, overflow policy: 0 = ignore extra digit; 1 = restart entry with the extra digit.
CNT_W, $clog2(MAX_DIGITS+1), localparam, width of digit_count.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
inputNums  in  10  one-hot key lines, bit i = digit i
enter  in  1  commit strobe (level; rising edge acted on)
clear  in  1  abort strobe (level; rising edge acted on)
bksp  in  1  backspace (present only with DIGIT_BACKSPACE_EN)
entry_val  out  OUT_W  live accumulator value
digit_count  out  CNT_W  digits currently entered
out_val  out  OUT_W  last committed value
out_valid  out  1  one-cycle pulse when out_val is updated
overflow  out  1  one-cycle pulse when a digit arrives in FULL
busy  out  1  high when state != EMPTY

Behaviour:
Reset (rst_n low, async):
- All outputs 0; state EMPTY; all input pipeline registers 0.

Input stage:
- inputNums, enter, clear (and bksp) are registered twice: _q, then _qq.

Events, evaluated on the same rising edge:
- Digit press: inputNums_q exactly one-hot AND inputNums_qq == 0. A release to all-zero is required between presses.
- Multi-hot codes are ignored and do not count as a release.
- Enter/clear/bksp events: x_q & ~x_qq.
- Latency: key first sampled at edge k -> entry_val/digit_count updated at edge k+1.

Priority when events coincide: clear > enter > bksp > digit. Lower-priority events in the same cycle are dropped.

Arithmetic:
- new = entry_val*10 + d, computed at OUT_W+4 bits and truncated to OUT_W. This is lossless given the OUT_W constraint.

States (digit_count tracks the state):
- EMPTY (count 0):
  - digit -> count 1, ENTRY (FULL if MAX_DIGITS==1).
  - Digit 0 counts as a digit: leading zeros consume capacity.
- ENTRY (0 < count < MAX_DIGITS):
  - digit -> accumulate, count+1; goes to FULL when count reaches MAX_DIGITS.
- FULL (count == MAX_DIGITS), on digit:
  - overflow pulses.
  - WRAP_MODE=0: entry_val and count unchanged.
  - WRAP_MODE=1: entry_val = d, count = 1, ENTRY.

Enter (any state):
- out_val <= entry_val; out_valid pulses 1 cycle; entry_val, count <= 0; EMPTY.
- Enter in EMPTY commits 0 with a pulse.

Clear (any state):
- entry_val, count, out_val <= 0; no out_valid pulse; EMPTY.

Strobes:
- out_valid and overflow are never high for more than 1 cycle per event.
- Held keys or held enter produce exactly one event.

Reset mid-entry: immediate return to reset values; a key still held at reset release is accepted once its _qq stage has seen 0 after reset.

Optional Feature:
DIGIT_BACKSPACE_EN
- Defined: bksp port exists.
  - bksp event in ENTRY/FULL -> entry_val = entry_val/10, count-1; state follows count.
  - bksp event in EMPTY is a no-op; no strobes.
- Undefined: no bksp port and no divider logic; behaviour otherwise identical.

Test Plan:
- MAX_DIGITS=4: press 1,2,3,4 (release between) -> entry_val 1234, count 4, busy 1. Enter -> out_val 1234, out_valid high exactly 1 cycle, entry_val 0, busy 0.
- FULL at 1234, press 5: WRAP_MODE=0 -> overflow 1 cycle, entry_val stays 1234. WRAP_MODE=1 -> overflow pulse, entry_val 5, count 1.
- Hold inputNums=0b0010000000 for 10 cycles -> single digit 7 accepted. Apply 0b0000010010 -> ignored, count unchanged.
- Enter a digit and assert enter and clear in the same cycle after entering 42 -> clear wins: out_val 0, no out_valid. Enter in EMPTY -> out_val 0 with out_valid pulse.
- Enter 98, pull rst_n low mid-cycle -> all outputs 0 asynchronously. After release, press 3 -> entry_val 3.
- With DIGIT_BACKSPACE_EN: enter 567, bksp -> entry_val 56, count 2. bksp twice more -> 0, EMPTY. Further bksp -> no change.
